// File: rtl/integer_execute_pkg.sv
// Shared types and constants for the integer execute stage: issue packet layout,
// ALU/branch funct3 encodings and the execute class decode helper.
package integer_execute_pkg;

    localparam int unsigned XLEN_DEF      = 32;
    localparam int unsigned ROB_ID_WIDTH  = 6;
    localparam int unsigned PC_WIDTH      = 32;
    localparam int unsigned REDIRECT_PC_W = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef struct packed {
        logic                    entry_valid;
        logic [ROB_ID_WIDTH-1:0] rob_id;
        logic [PC_WIDTH-1:0]     pc;
        logic [XLEN_DEF-1:0]     src1_data;
        logic [XLEN_DEF-1:0]     src2_data;
        logic [XLEN_DEF-1:0]     imm;
        logic [2:0]              funct3;
        logic                    is_r_type;
        logic                    is_i_type;
        logic                    is_u_type;
        logic                    is_lui;
        logic                    is_jal;
        logic                    is_jalr;
        logic                    is_b_type;
        logic                    is_sub;
        logic                    is_sra_srai;
        logic                    br_dir_pred;
    } iiq_issue_data_t;

    localparam int unsigned IIQ_ISSUE_DATA_WIDTH = $bits(iiq_issue_data_t);

    typedef enum logic [2:0] {
        ClsAlu,
        ClsUpper,
        ClsJal,
        ClsJalr,
        ClsBranch
    } exec_class_e;

    // Control-flow flags win over the ALU path if a malformed packet sets several.
    function automatic exec_class_e decode_class(input iiq_issue_data_t p);
        if (p.is_b_type) return ClsBranch;
        if (p.is_jalr)   return ClsJalr;
        if (p.is_jal)    return ClsJal;
        if (p.is_u_type) return ClsUpper;
        return ClsAlu;
    endfunction

endpackage

// File: rtl/integer_execute_alu.sv
// Single-cycle integer ALU for R/I-type operations, selected by funct3.
module int_alu
    import integer_execute_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic [2:0]      funct3,
    input  logic            is_sub_eff,
    input  logic            is_sra,
    output logic [XLEN-1:0] result
);

    localparam int unsigned ShW = $clog2(XLEN);

    logic [ShW-1:0] shamt;

    assign shamt = operand2[ShW-1:0];

    always_comb begin
        result = '0;
        unique case (funct3)
            ALU_ADD:  result = is_sub_eff ? operand1 - operand2 : operand1 + operand2;
            ALU_SLL:  result = operand1 << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(operand1) < $signed(operand2)};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, operand1 < operand2};
            ALU_XOR:  result = operand1 ^ operand2;
            ALU_SRL:  result = is_sra ? XLEN'($signed(operand1) >>> shamt) : operand1 >> shamt;
            ALU_OR:   result = operand1 | operand2;
            ALU_AND:  result = operand1 & operand2;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/integer_execute.sv
// Integer execute stage: one-cycle execute with combinational result broadcast,
// registered ROB completion and a registered one-cycle fetch redirect / flush.
module integer_execute
    import integer_execute_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned ROB_ID_W = ROB_ID_WIDTH,
    parameter int unsigned PC_W     = REDIRECT_PC_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IIQ_ISSUE_DATA_WIDTH-1:0] issue_data,
    output logic                            alu_broadcast_valid,
    output logic [ROB_ID_W-1:0]             alu_broadcast_rob_id,
    output logic [XLEN-1:0]                 alu_broadcast_reg_data,
    output logic                            rob_complete_valid,
    output logic [ROB_ID_W-1:0]             rob_complete_rob_id,
    output logic [XLEN-1:0]                 rob_complete_data,
    output logic                            rob_complete_mispred,
    output logic                            fetch_redirect_valid,
    output logic [PC_W-1:0]                 fetch_redirect_pc,
    output logic [31:0]                     mispred_count
);

    iiq_issue_data_t pkt;
    exec_class_e     cls;

    logic            ex_v;
    logic [XLEN-1:0] operand2;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] result;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] pc_plus_imm;
    logic [PC_W-1:0] jalr_target;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] redirect_pc;
    logic            br_taken;
    logic            actual_taken;
    logic            mispred;

    logic                rob_complete_valid_q;
    logic [ROB_ID_W-1:0] rob_complete_rob_id_q;
    logic [XLEN-1:0]     rob_complete_data_q;
    logic                rob_complete_mispred_q;
    logic                fetch_redirect_valid_q;
    logic [PC_W-1:0]     fetch_redirect_pc_q;
    logic [31:0]         mispred_count_q;

    assign pkt = iiq_issue_data_t'(issue_data);
    assign cls = decode_class(pkt);

    // The redirect cycle doubles as the flush, so anything arriving then is squashed.
    assign ex_v = pkt.entry_valid && !fetch_redirect_valid_q;

    assign operand2    = pkt.is_r_type ? XLEN'(pkt.src2_data) : XLEN'(pkt.imm);
    assign pc_plus4    = PC_W'(pkt.pc) + PC_W'(4);
    assign pc_plus_imm = PC_W'(pkt.pc) + PC_W'(pkt.imm);
    assign jalr_target = (PC_W'(pkt.src1_data) + PC_W'(pkt.imm)) & ~PC_W'(1);

    int_alu #(
        .XLEN(XLEN)
    ) u_int_alu (
        .operand1  (XLEN'(pkt.src1_data)),
        .operand2  (operand2),
        .funct3    (pkt.funct3),
        .is_sub_eff(pkt.is_r_type && pkt.is_sub),
        .is_sra    (pkt.is_sra_srai),
        .result    (alu_result)
    );

    always_comb begin
        br_taken = 1'b0;
        case (pkt.funct3)
            BR_BEQ:  br_taken = pkt.src1_data == pkt.src2_data;
            BR_BNE:  br_taken = pkt.src1_data != pkt.src2_data;
            BR_BLT:  br_taken = $signed(pkt.src1_data) < $signed(pkt.src2_data);
            BR_BGE:  br_taken = $signed(pkt.src1_data) >= $signed(pkt.src2_data);
            BR_BLTU: br_taken = pkt.src1_data < pkt.src2_data;
            BR_BGEU: br_taken = pkt.src1_data >= pkt.src2_data;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        result       = alu_result;
        target       = pc_plus_imm;
        actual_taken = 1'b0;
        mispred      = 1'b0;
        unique case (cls)
            ClsBranch: begin
                result       = '0;
                actual_taken = br_taken;
                mispred      = br_taken != pkt.br_dir_pred;
            end
            ClsJal: begin
                result       = XLEN'(pc_plus4);
                actual_taken = 1'b1;
                mispred      = !pkt.br_dir_pred;
            end
            ClsJalr: begin
                // Predicted target is not carried in the packet, so jalr always redirects.
                result       = XLEN'(pc_plus4);
                target       = jalr_target;
                actual_taken = 1'b1;
                mispred      = 1'b1;
            end
            ClsUpper: begin
                result = pkt.is_lui ? XLEN'(pkt.imm) : XLEN'(pc_plus_imm);
            end
            ClsAlu: begin
                result = alu_result;
            end
            default: begin
                result = alu_result;
            end
        endcase
    end

    assign redirect_pc = actual_taken ? target : pc_plus4;

    assign alu_broadcast_valid    = ex_v;
    assign alu_broadcast_rob_id   = ROB_ID_W'(pkt.rob_id);
    assign alu_broadcast_reg_data = result;

    always_ff @(posedge clk) begin
        if (rst) begin
            rob_complete_valid_q   <= 1'b0;
            rob_complete_rob_id_q  <= '0;
            rob_complete_data_q    <= '0;
            rob_complete_mispred_q <= 1'b0;
            fetch_redirect_valid_q <= 1'b0;
            fetch_redirect_pc_q    <= '0;
            mispred_count_q        <= '0;
        end else begin
            rob_complete_valid_q   <= ex_v;
            rob_complete_rob_id_q  <= ROB_ID_W'(pkt.rob_id);
            rob_complete_data_q    <= result;
            rob_complete_mispred_q <= ex_v && mispred;
            fetch_redirect_valid_q <= ex_v && mispred;
            fetch_redirect_pc_q    <= redirect_pc;
            if (ex_v && mispred && (mispred_count_q != '1)) begin
                mispred_count_q <= mispred_count_q + 32'd1;
            end
        end
    end

    assign rob_complete_valid   = rob_complete_valid_q;
    assign rob_complete_rob_id  = rob_complete_rob_id_q;
    assign rob_complete_data    = rob_complete_data_q;
    assign rob_complete_mispred = rob_complete_mispred_q;
    assign fetch_redirect_valid = fetch_redirect_valid_q;
    assign fetch_redirect_pc    = fetch_redirect_pc_q;
    assign mispred_count        = mispred_count_q;

endmodule
